// File: rtl/aes_key_expand_seq.sv
// Sequential AES key expansion: one schedule word per clock, with round-key read port.
// Word storage is filled in place; per-word "generated" flags let a cipher consume
// completed rounds while expansion is still running.
module aes_key_expand_seq #(
   parameter int unsigned MAX_NK = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key,
   output logic         busy,
   output logic         done,
   output logic         err,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   output logic         rd_valid,
   output logic [127:0] rd_data,
   output logic         rd_hit
);

   localparam int unsigned Depth = 4 * (MAX_NK + 7);

   typedef enum logic {StIdle, StExpand} state_e;

   state_e        state_q, state_d;
   logic [31:0]   w_q [Depth];
   logic [Depth-1:0] gen_q;
   logic [Depth-1:0] gen_init;
   logic [3:0]    nk_q;
   logic [5:0]    wlen_q;
   logic [5:0]    idx_q;
   logic [2:0]    mod_q;
   logic [7:0]    rcon_q;
   logic          loaded_q;
   logic          done_q;
   logic          err_q;
   logic          rd_valid_q;
   logic [127:0]  rd_data_q;
   logic          rd_hit_q;

   logic [3:0]    req_nk;
   logic          legal;
   logic          accept;
   logic          reject;
   logic          expanding;
   logic          last;
   logic [5:0]    idx_prev;
   logic [5:0]    idx_old;
   logic [31:0]   prev_word;
   logic [31:0]   old_word;
   logic [31:0]   sub_in;
   logic [31:0]   sub_out;
   logic [31:0]   t_word;
   logic [31:0]   new_word;
   logic [3:0]    nr;
   logic [5:0]    rd_base;
   logic          rd_in_range;
   logic [127:0]  rd_word;
   logic          rd_flags;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
   endfunction

   // Start decode: key length, legality and the resulting request type.
   always_comb begin
      req_nk = 4'd0;
      unique case (key_len)
         2'b00:   req_nk = 4'd4;
         2'b01:   req_nk = 4'd6;
         2'b10:   req_nk = 4'd8;
         default: req_nk = 4'd0;
      endcase
      legal     = (key_len != 2'b11) && (int'(req_nk) <= int'(MAX_NK));
      accept    = start && (state_q == StIdle) && legal;
      reject    = start && (state_q == StIdle) && !legal;
      expanding = (state_q == StExpand);
      last      = expanding && (idx_q == wlen_q - 6'd1);
      for (int i = 0; i < int'(Depth); i++) begin
         gen_init[i] = (i < int'(req_nk));
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StExpand;
         StExpand: if (last)   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      busy     = (state_q == StExpand);
      done     = done_q;
      err      = err_q;
      rd_valid = rd_valid_q;
      rd_data  = rd_data_q;
      rd_hit   = rd_hit_q;
   end

   // Next schedule word; SubWord is shared between the RotWord step and the Nk=8 mid step.
   always_comb begin
      idx_prev  = idx_q - 6'd1;
      idx_old   = idx_q - {2'b00, nk_q};
      prev_word = w_q[idx_prev];
      old_word  = w_q[idx_old];
      sub_in    = (mod_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
      sub_out   = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
      if (mod_q == 3'd0)                         t_word = sub_out ^ {rcon_q, 24'h0};
      else if ((nk_q == 4'd8) && (mod_q == 3'd4)) t_word = sub_out;
      else                                       t_word = prev_word;
      new_word  = old_word ^ t_word;
   end

   // Expansion control: counters, rcon, generated flags and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         nk_q     <= 4'd0;
         wlen_q   <= 6'd0;
         idx_q    <= 6'd0;
         mod_q    <= 3'd0;
         rcon_q   <= 8'h00;
         loaded_q <= 1'b0;
         gen_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= last;
         err_q  <= reject;
         if (accept) begin
            nk_q     <= req_nk;
            wlen_q   <= {req_nk, 2'b00} + 6'd28;
            idx_q    <= {2'b00, req_nk};
            mod_q    <= 3'd0;
            rcon_q   <= 8'h01;
            loaded_q <= 1'b1;
            gen_q    <= gen_init;
         end else if (expanding) begin
            gen_q[idx_q] <= 1'b1;
            idx_q        <= idx_q + 6'd1;
            mod_q        <= (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
            if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
         end
      end
   end

   // Word storage; deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            for (int i = 0; i < int'(MAX_NK); i++) begin
               if (i < int'(req_nk)) w_q[i] <= key[255-32*i -: 32];
            end
         end else if (expanding) begin
            w_q[idx_q] <= new_word;
         end
      end
   end

   // Round-key lookup against pre-edge storage and flags.
   always_comb begin
      nr          = nk_q + 4'd6;
      rd_base     = {rd_round, 2'b00};
      rd_in_range = loaded_q && (rd_round <= nr);
      rd_word     = '0;
      rd_flags    = 1'b0;
      if (rd_in_range) begin
         rd_word  = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2],
                     w_q[rd_base + 6'd3]};
         rd_flags = gen_q[rd_base] & gen_q[rd_base + 6'd1] & gen_q[rd_base + 6'd2]
                    & gen_q[rd_base + 6'd3];
      end
   end

   // Read response register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         rd_data_q  <= rd_en ? rd_word : '0;
         rd_hit_q   <= rd_en && rd_flags;
      end
   end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: FIPS-197 vectors plus random keys against a reference model.
module tb_aes_key_expand_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic         busy;
   logic         done;
   logic         err;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic         rd_valid;
   logic [127:0] rd_data;
   logic         rd_hit;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  sbox_tab [256];
   logic [31:0] ref_w [60];

   aes_key_expand_seq #(.MAX_NK(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_len  (key_len),
      .key      (key),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rd_en    (rd_en),
      .rd_round (rd_round),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_hit   (rd_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // S-box table built by brute-force inverse search and bitwise affine transform.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         for (int i = 0; i < 8; i++) begin
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                   ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 8'h00;
         end
         sbox_tab[x] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int j);
      logic [7:0] r = 8'h01;
      for (int i = 1; i < j; i++) r = gmul(r, 8'h02);
      return r;
   endfunction

   task automatic ref_expand(input logic [255:0] k, input int nk);
      int total = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) ref_w[i] = k[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         logic [31:0] temp = ref_w[i-1];
         if (i % nk == 0)
            temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_of(i / nk), 24'h0};
         else if (nk > 6 && i % nk == 4)
            temp = sub_word(temp);
         ref_w[i] = ref_w[i-nk] ^ temp;
      end
   endtask

   function automatic logic [127:0] ref_round(input int r);
      return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] len, input logic [255:0] k);
      start   = 1'b1;
      key_len = len;
      key     = k;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_read(input int r);
      rd_en    = 1'b1;
      rd_round = 4'(r);
      tick();
      rd_en    = 1'b0;
      chk("rd_valid", 128'(rd_valid), 128'd1);
   endtask

   // Compare every round 0..Nr against the model and the first out-of-range round.
   task automatic check_all_rounds(input int nk);
      for (int r = 0; r <= nk + 6; r++) begin
         do_read(r);
         chk($sformatf("round%0d_data", r), rd_data, ref_round(r));
         chk($sformatf("round%0d_hit", r), 128'(rd_hit), 128'd1);
      end
      do_read(nk + 7);
      chk("oob_data", rd_data, 128'd0);
      chk("oob_hit", 128'(rd_hit), 128'd0);
   endtask

   initial begin
      logic [255:0] k;
      int           lat;
      int           nk;
      logic [1:0]   len;
      logic         exp_hit;
      logic         saw_done;

      build_sbox();
      rst = 1'b1; start = 1'b0; key_len = 2'b00; key = '0; rd_en = 1'b0; rd_round = 4'd0;
      repeat (2) tick();
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_rd_valid", 128'(rd_valid), 128'd0);
      chk("rst_rd_hit", 128'(rd_hit), 128'd0);
      chk("rst_rd_data", rd_data, 128'd0);
      rst = 1'b0;
      tick();

      // Read before any key has been loaded.
      do_read(0);
      chk("prestart_data", rd_data, 128'd0);
      chk("prestart_hit", 128'(rd_hit), 128'd0);

      // AES-128 vector with round 1 read on every cycle.
      k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
      ref_expand(k, 4);
      rd_en = 1'b1; rd_round = 4'd1;
      do_start(2'b00, k);
      chk("a128_busy", 128'(busy), 128'd1);
      chk("a128_hit_e0", 128'(rd_hit), 128'd0);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
         exp_hit = (4 + lat - 1) >= 8;
         chk($sformatf("a128_hit_e%0d", lat), 128'(rd_hit), 128'(exp_hit));
         if (exp_hit) chk($sformatf("a128_r1_e%0d", lat), rd_data, ref_round(1));
      end
      rd_en = 1'b0;
      chk("a128_latency", 128'(lat), 128'd40);
      chk("a128_busy_done", 128'(busy), 128'd0);
      tick();
      chk("a128_done_pulse", 128'(done), 128'd0);
      do_read(10);
      chk("a128_r10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("a128_r10_hit", 128'(rd_hit), 128'd1);
      do_read(11);
      chk("a128_r11_data", rd_data, 128'd0);
      chk("a128_r11_hit", 128'(rd_hit), 128'd0);
      check_all_rounds(4);

      // AES-192 vector.
      k = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
      ref_expand(k, 6);
      do_start(2'b01, k);
      wait_done(lat);
      chk("a192_latency", 128'(lat), 128'd46);
      do_read(12);
      chk("a192_r12", rd_data, 128'he98ba06f448c773c8ecc720401002202);
      chk("a192_r12_hit", 128'(rd_hit), 128'd1);
      check_all_rounds(6);

      // AES-256 vector.
      k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      ref_expand(k, 8);
      do_start(2'b10, k);
      wait_done(lat);
      chk("a256_latency", 128'(lat), 128'd52);
      do_read(14);
      chk("a256_r14", rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
      chk("a256_r14_hit", 128'(rd_hit), 128'd1);
      check_all_rounds(8);

      // Illegal key length: err pulse only, stored key untouched.
      do_start(2'b11, rand_key());
      chk("ill_err", 128'(err), 128'd1);
      chk("ill_busy", 128'(busy), 128'd0);
      tick();
      chk("ill_err_drop", 128'(err), 128'd0);
      chk("ill_busy2", 128'(busy), 128'd0);
      do_read(14);
      chk("ill_r14", rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
      chk("ill_r14_hit", 128'(rd_hit), 128'd1);

      // Starts while busy are ignored, illegal ones without err.
      k = rand_key();
      ref_expand(k, 4);
      do_start(2'b00, k);
      repeat (5) tick();
      do_start(2'b10, rand_key());
      chk("busy_start_err", 128'(err), 128'd0);
      do_start(2'b11, rand_key());
      chk("busy_ill_err", 128'(err), 128'd0);
      chk("busy_still", 128'(busy), 128'd1);
      wait_done(lat);
      chk("busy_latency", 128'(lat + 7), 128'd40);
      check_all_rounds(4);

      // Reset at cycle 20 of an AES-128 expansion.
      do_start(2'b00, rand_key());
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 128'(busy), 128'd0);
      chk("abort_done", 128'(done), 128'd0);
      saw_done = 1'b0;
      repeat (50) begin
         tick();
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("abort_no_done", 128'(saw_done), 128'd0);
      do_read(1);
      chk("abort_r1_hit", 128'(rd_hit), 128'd0);

      // Fresh starts with random keys and lengths.
      for (int it = 0; it < 5; it++) begin
         len = (it == 0) ? 2'b00 : 2'($urandom_range(0, 2));
         nk  = 4 + 2 * int'(len);
         k   = rand_key();
         ref_expand(k, nk);
         do_start(len, k);
         wait_done(lat);
         chk($sformatf("rand%0d_latency", it), 128'(lat), 128'(4 * (nk + 7) - nk));
         check_all_rounds(nk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_key_expand_seq.md
AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 Parameter MAX_NK, default 8, SHALL set the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; SHALL be synchronous and active-high.
REQ-004 start  in  1  single-cycle request to expand key.
REQ-005 key_len  in  2  key length code: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 = illegal.
REQ-006 key  in  256  cipher key, MSB-aligned: w[0] = key[255:224]; unused low bits are ignored.
REQ-007 busy  out  1  expansion in progress.
REQ-008 done  out  1  one-cycle pulse when the last word is written.
REQ-009 err  out  1  one-cycle pulse when a start is rejected.
REQ-010 rd_en  in  1  round-key read request.
REQ-011 rd_round  in  4  requested round index, 0..14.
REQ-012 rd_valid  out  1  read response strobe, one cycle after rd_en.
REQ-013 rd_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-014 rd_hit  out  1  all four words of the requested round are generated for the current key.

Function
REQ-015 States SHALL be IDLE and EXPAND; done is a registered pulse, not a state.
REQ-016 A start in IDLE with a legal key_len whose Nk <= MAX_NK SHALL do the following on that edge: load w[0..Nk-1] from key, latch Nk and W = 4*(Nr+1) (44/52/60), set idx = Nk, rcon = 0x01, clear all generated flags except words 0..Nk-1, set busy = 1, and enter EXPAND.
REQ-017 A start with key_len = 11, or with Nk > MAX_NK, SHALL be ignored except for a one-cycle err pulse; stored words and flags SHALL be unchanged.
REQ-018 A start while busy = 1 SHALL be ignored, with no err pulse.
REQ-019 Each EXPAND edge SHALL write exactly one word, w[idx] = w[idx-Nk] ^ t, then increment idx.
- If idx mod Nk = 0: t = SubWord(RotWord(w[idx-1])) ^ {rcon, 24'h0}, and rcon is then updated to xtime(rcon) (0x80 -> 0x1B).
- If Nk = 8 and idx mod 8 = 4: t = SubWord(w[idx-1]).
- Otherwise: t = w[idx-1].
REQ-020 SubWord SHALL use an internal combinational FIPS-197 S-box with no file load and no initial block.
REQ-021 The edge that writes w[W-1] SHALL return the block to IDLE, drop busy and raise done for exactly one cycle.
- Start-to-done latency is W-Nk edges: 40 (AES-128), 46 (AES-192) or 52 (AES-256).
REQ-022 Word storage SHALL hold 4*(MAX_NK+7) words; idx and the mod-Nk tracking SHALL use counters, not dividers.
REQ-023 Read requests SHALL be accepted in any state; rd_valid SHALL equal the previous-cycle rd_en.
REQ-024 rd_data SHALL reflect pre-edge storage contents; a read that coincides with the write completing a round SHALL return rd_hit = 0.
REQ-025 rd_round > Nr of the latched key, or any round before the first legal start, SHALL return rd_data = 0 and rd_hit = 0.
REQ-026 Reading during EXPAND SHALL return rd_hit = 1 for completed rounds, enabling pipelined use by the cipher.

Reset
REQ-027 On rst = 1 the block SHALL do the following:
- Outputs: busy, done, err, rd_valid, rd_hit = 0 and rd_data = 0.
- State: state = IDLE and all generated flags cleared.
- Word storage need not be cleared.
REQ-028 rst SHALL take priority over start and rd_en on the same edge; rst mid-expansion SHALL abort with no done pulse.

Verification
REQ-029 AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done 40 cycles after start; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, rd_hit = 1.
REQ-030 AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> done after 46 cycles; round 12 = e98ba06f 448c773c 8ecc7204 01002202.
REQ-031 AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> done after 52 cycles; round 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-032 key_len = 11 start -> err = 1 for one cycle, busy stays 0; a second start while busy -> ignored, and the original key's result is unchanged.
REQ-033 rst asserted at cycle 20 of an AES-128 expansion -> no done, busy = 0 next cycle, a read of round 1 returns rd_hit = 0; then a fresh start completes correctly.
REQ-034 Read round 1 every cycle during AES-128 expansion -> rd_hit = 0 until w[7] has been written, 1 afterwards; a read of round 11 -> rd_data = 0, rd_hit = 0.
